// File: rtl/pc_pkg.sv
// Shared constants for the fetch-stage PC unit: default geometry, vectors and
// the next-PC source encoding (also consumed by hazard/debug logic).
package pc_pkg;

   localparam int unsigned PC_WIDTH      = 32;
   localparam logic [31:0] RESET_PC_DEF  = 32'h0000_3000;
   localparam logic [31:0] EXC_VEC_DEF   = 32'h0000_4180;
   localparam int unsigned INC_DEF       = 4;
   localparam int unsigned RAS_DEPTH_DEF = 4;

   // Next-PC source encoding
   localparam int unsigned    SRC_W    = 3;
   localparam logic [SRC_W-1:0] SRC_SEQ  = 3'd0;
   localparam logic [SRC_W-1:0] SRC_BR   = 3'd1;
   localparam logic [SRC_W-1:0] SRC_RET  = 3'd2;
   localparam logic [SRC_W-1:0] SRC_JMP  = 3'd3;
   localparam logic [SRC_W-1:0] SRC_CALL = 3'd4;
   localparam logic [SRC_W-1:0] SRC_ERET = 3'd5;
   localparam logic [SRC_W-1:0] SRC_EXC  = 3'd6;

endpackage

// File: rtl/pc_unit_if.sv
// Fetch-control <-> PC unit bundle.
//  master: redirect requests in, PC/EPC/RAS status back.
//  slave : the PC unit itself.
interface pc_unit_if
   import pc_pkg::*;
#(
   parameter int unsigned WIDTH = PC_WIDTH
);
   logic             en;
   logic             br_taken;
   logic [WIDTH-1:0] br_target;
   logic             jmp;
   logic             call;
   logic [WIDTH-1:0] jmp_target;
   logic             ret;
   logic [WIDTH-1:0] ret_target;
   logic             exc;
   logic             eret;
   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] pc_plus;
   logic [WIDTH-1:0] epc;
   logic             ras_empty;
   logic             ras_full;

   modport master (
      output en, br_taken, br_target, jmp, call, jmp_target, ret, ret_target, exc, eret,
      input  pc, pc_plus, epc, ras_empty, ras_full
   );

   modport slave (
      input  en, br_taken, br_target, jmp, call, jmp_target, ret, ret_target, exc, eret,
      output pc, pc_plus, epc, ras_empty, ras_full
   );
endinterface

// File: rtl/ras_stack.sv
// Return-address stack: circular buffer with saturating occupancy count.
// A push when full overwrites the oldest entry. Ports: push/pop strobes
// (push wins if both), push_data, top (most recent entry), registered
// empty/full flags.
module ras_stack #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] top,
   output logic             empty,
   output logic             full
);
   localparam int unsigned PW = $clog2(RAS_DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [WIDTH-1:0] mem [RAS_DEPTH];
   logic [PW-1:0]    ptr, ptr_next;
   logic [CW-1:0]    count, count_next;

   // ptr is the next write slot; power-of-2 depth makes wrap free
   always_comb begin
      ptr_next   = ptr;
      count_next = count;
      if (push) begin
         ptr_next = ptr + PW'(1);
         if (count != CW'(RAS_DEPTH)) count_next = count + CW'(1);
      end else if (pop && (count != '0)) begin
         ptr_next   = ptr - PW'(1);
         count_next = count - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr   <= '0;
         count <= '0;
         empty <= 1'b1;
         full  <= 1'b0;
      end else begin
         ptr   <= ptr_next;
         count <= count_next;
         empty <= (count_next == '0);
         full  <= (count_next == CW'(RAS_DEPTH));
      end
   end

   // Storage needs no reset; occupancy gates every read
   always_ff @(posedge clk) begin
      if (push) mem[ptr] <= push_data;
   end

   assign top = mem[ptr - PW'(1)];
endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: prioritised next-PC selection
// (exc > eret > call > jmp > ret > branch > sequential), EPC register and
// return-address stack. Ports: clk, reset_n, bus (pc_unit_if.slave).
module pc_unit
   import pc_pkg::*;
#(
   parameter int unsigned     WIDTH     = PC_WIDTH,
   parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEF),
   parameter logic [WIDTH-1:0] EXC_VEC  = WIDTH'(EXC_VEC_DEF),
   parameter int unsigned     INC       = INC_DEF,
   parameter int unsigned     RAS_DEPTH = RAS_DEPTH_DEF
) (
   input  logic       clk,
   input  logic       reset_n,
   pc_unit_if.slave   bus
);
   logic [WIDTH-1:0] pc_q, epc_q, pc_next, epc_next, pc_plus_c, ras_top;
   logic [SRC_W-1:0] src;
   logic             adv, push, pop, ras_empty, ras_full;

   function automatic logic [WIDTH-1:0] align_word(input logic [WIDTH-1:0] a);
      return {a[WIDTH-1:2], 2'b00};
   endfunction

   assign pc_plus_c = pc_q + WIDTH'(INC);

   // Source arbitration; exc/eret bypass the stall
   always_comb begin
      src = SRC_SEQ;
      adv = 1'b0;
      if (bus.exc) begin
         src = SRC_EXC;
         adv = 1'b1;
      end else if (bus.eret) begin
         src = SRC_ERET;
         adv = 1'b1;
      end else if (bus.en) begin
         adv = 1'b1;
         if      (bus.call)     src = SRC_CALL;
         else if (bus.jmp)      src = SRC_JMP;
         else if (bus.ret)      src = SRC_RET;
         else if (bus.br_taken) src = SRC_BR;
         else                   src = SRC_SEQ;
      end
   end

   // Next-state values for pc/epc and RAS strobes of the winning source
   always_comb begin
      pc_next  = pc_q;
      epc_next = epc_q;
      push     = 1'b0;
      pop      = 1'b0;
      if (adv) begin
         case (src)
            SRC_EXC: begin
               pc_next  = EXC_VEC;
               epc_next = pc_q;
            end
            SRC_ERET: pc_next = epc_q;
            SRC_CALL: begin
               pc_next = align_word(bus.jmp_target);
               push    = 1'b1;
            end
            SRC_JMP:  pc_next = align_word(bus.jmp_target);
            SRC_RET: begin
               if (!ras_empty) begin
                  pc_next = ras_top;
                  pop     = 1'b1;
               end else begin
                  pc_next = align_word(bus.ret_target);
               end
            end
            SRC_BR:   pc_next = align_word(bus.br_target);
            default:  pc_next = pc_plus_c;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_q  <= RESET_PC;
         epc_q <= '0;
      end else begin
         pc_q  <= pc_next;
         epc_q <= epc_next;
      end
   end

   ras_stack #(
      .WIDTH     (WIDTH),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push),
      .pop       (pop),
      .push_data (pc_plus_c),
      .top       (ras_top),
      .empty     (ras_empty),
      .full      (ras_full)
   );

   assign bus.pc        = pc_q;
   assign bus.pc_plus   = pc_plus_c;
   assign bus.epc       = epc_q;
   assign bus.ras_empty = ras_empty;
   assign bus.ras_full  = ras_full;
endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios with literal
// expectations, then randomized traffic against a queue-based reference model.
module tb_pc_unit;
   localparam int unsigned DEPTH = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_pass = 0;
   int   n_tot  = 0;
   bit   chk_on = 1'b1;

   pc_unit_if #(.WIDTH(32)) bus ();

   pc_unit dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Reference model
   logic [31:0] m_pc, m_epc;
   logic [31:0] m_ras[$];

   always @(posedge clk or negedge reset_n) begin
      logic [31:0] plus;
      if (!reset_n) begin
         m_pc  = 32'h0000_3000;
         m_epc = 32'h0;
         m_ras.delete();
      end else begin
         plus = m_pc + 32'd4;
         if (bus.exc) begin
            m_epc = m_pc;
            m_pc  = 32'h0000_4180;
         end else if (bus.eret) begin
            m_pc = m_epc;
         end else if (bus.en) begin
            if (bus.call) begin
               m_ras.push_back(plus);
               if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
               m_pc = bus.jmp_target & ~32'h3;
            end else if (bus.jmp) begin
               m_pc = bus.jmp_target & ~32'h3;
            end else if (bus.ret) begin
               if (m_ras.size() > 0) m_pc = m_ras.pop_back();
               else                  m_pc = bus.ret_target & ~32'h3;
            end else if (bus.br_taken) begin
               m_pc = bus.br_target & ~32'h3;
            end else begin
               m_pc = plus;
            end
         end
      end
   end

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h @%0t", name, act, exp, $time);
   endfunction

   // Cycle-by-cycle compare against the model
   always @(negedge clk) begin
      if (chk_on) begin
         check("pc",        bus.pc,               m_pc);
         check("pc_plus",   bus.pc_plus,          m_pc + 32'd4);
         check("epc",       bus.epc,              m_epc);
         check("ras_empty", 32'(bus.ras_empty),   32'(m_ras.size() == 0));
         check("ras_full",  32'(bus.ras_full),    32'(m_ras.size() == DEPTH));
      end
   end

   task automatic clr();
      bus.en = 1'b0; bus.br_taken = 1'b0; bus.jmp = 1'b0; bus.call = 1'b0;
      bus.ret = 1'b0; bus.exc = 1'b0; bus.eret = 1'b0;
      bus.br_target = '0; bus.jmp_target = '0; bus.ret_target = '0;
   endtask

   // Advance one clock; returns at the following negedge with inputs cleared
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
      clr();
   endtask

   task automatic do_call(input logic [31:0] t);
      bus.en = 1'b1; bus.call = 1'b1; bus.jmp_target = t; cyc();
   endtask

   task automatic do_ret(input logic [31:0] rt);
      bus.en = 1'b1; bus.ret = 1'b1; bus.ret_target = rt; cyc();
   endtask

   task automatic do_jmp(input logic [31:0] t);
      bus.en = 1'b1; bus.jmp = 1'b1; bus.jmp_target = t; cyc();
   endtask

   initial begin
      clr();
      @(negedge clk);
      check("rst_pc",    bus.pc,             32'h3000);
      check("rst_epc",   bus.epc,            32'h0);
      check("rst_empty", 32'(bus.ras_empty), 32'd1);
      check("rst_full",  32'(bus.ras_full),  32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // Sequential
      bus.en = 1'b1; cyc(); check("seq1", bus.pc, 32'h3004);
      bus.en = 1'b1; cyc(); check("seq2", bus.pc, 32'h3008);
      bus.en = 1'b1; cyc(); check("seq3", bus.pc, 32'h300C);

      // Stall and priority
      bus.br_taken = 1'b1; bus.br_target = 32'h3100; cyc();
      check("stall", bus.pc, 32'h300C);
      bus.en = 1'b1; bus.br_taken = 1'b1; bus.br_target = 32'h3100;
      bus.jmp = 1'b1; bus.jmp_target = 32'h3200; cyc();
      check("jmp_over_br", bus.pc, 32'h3200);

      // Exception / eret
      do_jmp(32'h3010);
      bus.exc = 1'b1; cyc();
      check("exc_pc",  bus.pc,  32'h4180);
      check("exc_epc", bus.epc, 32'h3010);
      bus.eret = 1'b1; cyc();
      check("eret_pc", bus.pc, 32'h3010);
      bus.exc = 1'b1; bus.eret = 1'b1; cyc();
      check("exc_eret", bus.pc, 32'h4180);

      // Asynchronous reset mid-run
      #2 reset_n = 1'b0;
      #1 check("async_rst", bus.pc, 32'h3000);
      @(negedge clk);
      reset_n = 1'b1;

      // RAS nesting
      do_call(32'h3400); check("call1", bus.pc, 32'h3400);
      do_call(32'h3800); check("call2", bus.pc, 32'h3800);
      do_ret(32'h0);     check("ret1",  bus.pc, 32'h3404);
      do_ret(32'h0);     check("ret2",  bus.pc, 32'h3004);
      check("ret_empty", 32'(bus.ras_empty), 32'd1);
      do_ret(32'h3050);  check("ret_arch", bus.pc, 32'h3050);

      // call+ret together: call wins, no pop
      bus.en = 1'b1; bus.call = 1'b1; bus.ret = 1'b1; bus.jmp_target = 32'h3600; cyc();
      check("call_ret", bus.pc, 32'h3600);
      do_ret(32'h0); check("call_ret_pop", bus.pc, 32'h3054);

      // call under stall pushes nothing
      bus.call = 1'b1; bus.jmp_target = 32'h3700; cyc();
      check("call_stall_empty", 32'(bus.ras_empty), 32'd1);

      // Overflow: links 3058, 5004, 5104, 5204, 5304
      do_call(32'h5000); do_call(32'h5100); do_call(32'h5200);
      do_call(32'h5300); do_call(32'h5400);
      check("ovf_full", 32'(bus.ras_full), 32'd1);
      do_ret(32'h0); check("ovf_r1", bus.pc, 32'h5304);
      do_ret(32'h0); check("ovf_r2", bus.pc, 32'h5204);
      do_ret(32'h0); check("ovf_r3", bus.pc, 32'h5104);
      do_ret(32'h0); check("ovf_r4", bus.pc, 32'h5004);
      check("ovf_empty", 32'(bus.ras_empty), 32'd1);

      // Wrap and alignment
      do_jmp(32'hFFFF_FFFC);
      check("pc_plus_wrap", bus.pc_plus, 32'h0);
      bus.en = 1'b1; cyc(); check("wrap", bus.pc, 32'h0);
      bus.en = 1'b1; bus.br_taken = 1'b1; bus.br_target = 32'h3103; cyc();
      check("align", bus.pc, 32'h3100);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         reset_n = 1'b1;
         bus.en         = ($urandom_range(0, 3) != 0);
         bus.exc        = ($urandom_range(0, 15) == 0);
         bus.eret       = ($urandom_range(0, 15) == 0);
         bus.call       = ($urandom_range(0, 5) == 0);
         bus.ret        = ($urandom_range(0, 4) == 0);
         bus.jmp        = ($urandom_range(0, 7) == 0);
         bus.br_taken   = ($urandom_range(0, 3) == 0);
         bus.br_target  = $urandom;
         bus.jmp_target = $urandom;
         bus.ret_target = $urandom;
         if ($urandom_range(0, 299) == 0) #2 reset_n = 1'b0;
         @(negedge clk);
      end
      reset_n = 1'b1;
      clr();
      @(negedge clk);
      chk_on = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
